// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial CLA adder: slice width, FSM encoding
// and the nibble-index width helper.
package cla_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_state_t;

  // Index width for WIDTH/NIBBLE nibbles; never narrower than one bit.
  function automatic int idx_width(input int width);
    int n;
    n = width / NIBBLE;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla.sv
// 4-bit carry-lookahead adder slice shared by the nibble-serial adder.
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] res,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign res  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit adder that pushes one nibble per cycle, LSB first, through a single
// 4-bit CLA slice, chaining the carry through a register.
//
// Handshakes: a transfer happens on an edge where valid && ready are both high.
// in_ready is high only in IDLE; out_valid is high only in DONE and holds
// res/cout/ovf stable until out_ready is seen.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output cla_state_t       state
);

  localparam int N  = WIDTH / NIBBLE;
  localparam int IW = idx_width(WIDTH);

  if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [IW-1:0]     idx;
  logic              carry;
  logic [NIBBLE-1:0] nib_a;
  logic [NIBBLE-1:0] nib_b;
  logic [NIBBLE-1:0] nib_sum;
  logic              nib_cout;
  logic              c_msb;
  int                base;

  assign base  = int'(idx) * NIBBLE;
  assign nib_a = a_q[base +: NIBBLE];
  assign nib_b = b_q[base +: NIBBLE];

  cla u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .res  (nib_sum),
    .cout (nib_cout)
  );

  // Carry into the top bit of the current slice, recovered from its sum bit.
  assign c_msb = nib_a[NIBBLE-1] ^ nib_b[NIBBLE-1] ^ nib_sum[NIBBLE-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      res       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            carry    <= cin;
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          res[base +: NIBBLE] <= nib_sum;
          carry               <= nib_cout;
          if (idx == IW'(N - 1)) begin
            cout      <= nib_cout;
            ovf       <= nib_cout ^ c_msb;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder: a 16-bit instance for directed, random, backpressure
// and reset cases, and a 4-bit instance swept exhaustively.
module tb_cla_seq_adder;
  import cla_pkg::*;

  logic clk;
  logic rst_n;

  logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16;
  logic [15:0] a16, b16, res16;
  logic        cout16, ovf16, busy16;
  cla_state_t  st16;

  logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4;
  logic [3:0]  a4, b4, res4;
  logic        cout4, ovf4, busy4;
  cla_state_t  st4;

  logic [17:0] exp_q[$];
  logic [5:0]  exp4_q[$];

  int checks;
  int passes;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
    .res(res16), .cout(cout16), .ovf(ovf16), .busy(busy16), .state(st16)
  );

  cla_seq_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .res(res4), .cout(cout4), .ovf(ovf4), .busy(busy4), .state(st4)
  );

  // Reference model: {cout, ovf, res} from plain integer addition and the signed-overflow rule.
  function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] s;
    logic        v;
    s = {1'b0, x} + {1'b0, y} + {16'b0, c};
    v = (x[15] == y[15]) && (s[15] != x[15]);
    return {s[16], v, s[15:0]};
  endfunction

  function automatic logic [5:0] model4(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] s;
    logic       v;
    s = {1'b0, x} + {1'b0, y} + {4'b0, c};
    v = (x[3] == y[3]) && (s[3] != x[3]);
    return {s[4], v, s[3:0]};
  endfunction

  // Drives one op into u16 with out_ready=1, checks latency (edges counted from the
  // handshake edge inclusive) and the result against the queued expectation.
  task automatic run_op16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                          input string name);
    int          guard;
    int          edges;
    logic [17:0] e;
    @(negedge clk);
    a16 = ta; b16 = tb_; cin16 = tc; in_valid16 = 1'b1; out_ready16 = 1'b1;
    guard = 0;
    while (!in_ready16 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!in_ready16) begin
      $display("FAIL %s_accept: in_ready=%b required 1", name, in_ready16);
      in_valid16 = 1'b0;
      return;
    end
    passes++;
    @(posedge clk);
    exp_q.push_back(model16(ta, tb_, tc));
    edges = 1;
    #1 in_valid16 = 1'b0;
    while (!out_valid16 && edges < 50) begin
      @(posedge clk);
      edges++;
      #1;
    end
    checks++;
    if (edges !== 5) $display("FAIL %s_latency: edges=%0d required 5", name, edges);
    else passes++;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({cout16, ovf16, res16} !== e)
      $display("FAIL %s_result: cout/ovf/res=%b/%b/%h required %b/%b/%h", name,
               cout16, ovf16, res16, e[17], e[16], e[15:0]);
    else passes++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (st16 !== IDLE || in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || res16 !== 16'h0 ||
        cout16 !== 1'b0 || ovf16 !== 1'b0 || busy16 !== 1'b0)
      $display("FAIL reset16: st=%0d rdy=%b ov=%b res=%h cout=%b ovf=%b busy=%b required 0/1/0/0000/0/0/0",
               st16, in_ready16, out_valid16, res16, cout16, ovf16, busy16);
    else passes++;
    checks++;
    if (st4 !== IDLE || in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || res4 !== 4'h0 || busy4 !== 1'b0)
      $display("FAIL reset4: st=%0d rdy=%b ov=%b res=%h busy=%b required 0/1/0/0/0",
               st4, in_ready4, out_valid4, res4, busy4);
    else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op16(16'h1234, 16'h0FFF, 1'b0, "vec_1234_0fff");
    run_op16(16'hFFFF, 16'h0001, 1'b0, "vec_ripple");
    run_op16(16'h7FFF, 16'h0000, 1'b1, "vec_posovf");
    run_op16(16'h8000, 16'h8000, 1'b0, "vec_negovf");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_busy();
    int guard;
    @(negedge clk);
    a16 = 16'h00F0; b16 = 16'h0010; cin16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk);
    #1 in_valid16 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy16 !== 1'b1 || in_ready16 !== 1'b0 || st16 !== RUN)
      $display("FAIL busy_run: busy=%b rdy=%b st=%0d required 1/0/1", busy16, in_ready16, st16);
    else passes++;
    guard = 0;
    while (!out_valid16 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (busy16 !== 1'b0 || res16 !== 16'h0100)
      $display("FAIL busy_done: busy=%b res=%h required 0/0100", busy16, res16);
    else passes++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int          guard;
    logic [17:0] e;
    logic [17:0] e2;
    @(negedge clk);
    a16 = 16'hABCD; b16 = 16'h1111; cin16 = 1'b1; in_valid16 = 1'b1; out_ready16 = 1'b0;
    @(posedge clk);
    exp_q.push_back(model16(16'hABCD, 16'h1111, 1'b1));
    #1;
    // New operands held valid while the result is stalled.
    a16 = 16'h4321; b16 = 16'h8765; cin16 = 1'b0;
    guard = 0;
    while (!out_valid16 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid16 !== 1'b1 || in_ready16 !== 1'b0 || {cout16, ovf16, res16} !== e)
        $display("FAIL bp_hold%0d: ov=%b rdy=%b cout/ovf/res=%b/%b/%h required 1/0/%b/%b/%h", i,
                 out_valid16, in_ready16, cout16, ovf16, res16, e[17], e[16], e[15:0]);
      else passes++;
    end
    out_ready16 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (st16 !== IDLE || out_valid16 !== 1'b0)
      $display("FAIL bp_release: st=%0d ov=%b required 0/0", st16, out_valid16);
    else passes++;
    @(posedge clk);
    exp_q.push_back(model16(16'h4321, 16'h8765, 1'b0));
    #1 in_valid16 = 1'b0;
    checks++;
    if (st16 !== RUN) $display("FAIL bp_accept: st=%0d required 1", st16);
    else passes++;
    guard = 0;
    while (!out_valid16 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    e2 = exp_q.pop_front();
    @(negedge clk);
    checks++;
    if ({cout16, ovf16, res16} !== e2)
      $display("FAIL bp_second: cout/ovf/res=%b/%b/%h required %b/%b/%h",
               cout16, ovf16, res16, e2[17], e2[16], e2[15:0]);
    else passes++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    a16 = 16'h5555; b16 = 16'h5555; cin16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk);
    #1 in_valid16 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (st16 !== IDLE || out_valid16 !== 1'b0 || res16 !== 16'h0 || in_ready16 !== 1'b1)
      $display("FAIL midrun_reset: st=%0d ov=%b res=%h rdy=%b required 0/0/0000/1",
               st16, out_valid16, res16, in_ready16);
    else passes++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid16 !== 1'b0) $display("FAIL midrun_noresult: ov=%b required 0", out_valid16);
    else passes++;
    run_op16(16'h0001, 16'h0001, 1'b0, "after_reset");
  endtask

  task automatic test_width4();
    int          guard;
    int          edges;
    logic [5:0]  e;
    logic [3:0]  ta;
    logic [3:0]  tb_;
    logic        tc;
    for (int i = 0; i < 512; i++) begin
      ta = 4'(i % 16);
      tb_ = 4'((i / 16) % 16);
      tc = 1'(i / 256);
      @(negedge clk);
      a4 = ta; b4 = tb_; cin4 = tc; in_valid4 = 1'b1; out_ready4 = 1'b1;
      guard = 0;
      while (!in_ready4 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      @(posedge clk);
      exp4_q.push_back(model4(ta, tb_, tc));
      edges = 1;
      #1 in_valid4 = 1'b0;
      while (!out_valid4 && edges < 20) begin
        @(posedge clk);
        edges++;
        #1;
      end
      checks++;
      if (edges !== 2) $display("FAIL w4_latency op%0d: edges=%0d required 2", i, edges);
      else passes++;
      @(negedge clk);
      e = exp4_q.pop_front();
      checks++;
      if ({cout4, ovf4, res4} !== e)
        $display("FAIL w4_result op%0d a=%h b=%h cin=%b: cout/ovf/res=%b/%b/%h required %b/%b/%h",
                 i, ta, tb_, tc, cout4, ovf4, res4, e[5], e[4], e[3:0]);
      else passes++;
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_directed();
    test_random();
    test_busy();
    test_backpressure();
    test_reset_mid_run();
    test_width4();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
